// File: rtl/spi_slave_endpoint.sv
// SPI mode-3 responder: synchronizes sclk/cs_bar/mosi into clk, shifts one
// MSB-first word in and one buffered response word out per chip-select frame.
module spi_slave_endpoint #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  cs_bar,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_done,
  output logic                  frame_error
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [SYNC_STAGES:0]   sclk_q;
  logic [SYNC_STAGES:0]   cs_q;
  logic [SYNC_STAGES-1:0] mosi_q;

  // sclk chain clears to its idle-high level so reset never fakes an edge;
  // cs chain clears low so a frame still open at reset lands in HOLD.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_q <= '1;
      cs_q   <= '0;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-1:0], sclk};
      cs_q   <= {cs_q[SYNC_STAGES-1:0], cs_bar};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
    end
  end

  logic sclk_s, sclk_p, cs_s, cs_p, mosi_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  assign sclk_s    = sclk_q[SYNC_STAGES-1];
  assign sclk_p    = sclk_q[SYNC_STAGES];
  assign cs_s      = cs_q[SYNC_STAGES-1];
  assign cs_p      = cs_q[SYNC_STAGES];
  assign mosi_s    = mosi_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_p;
  assign sclk_fall = ~sclk_s & sclk_p;
  assign cs_fall   = ~cs_s & cs_p;
  assign cs_rise   = cs_s & ~cs_p;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  tx_ready_q, tx_ready_d;
  logic                  miso_q, miso_d;
  logic                  ovr_q, ovr_d;
  logic                  rxv_q, rxv_d;
  logic                  txd_q, txd_d;
  logic                  ferr_q, ferr_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    hold_d     = hold_q;
    rx_data_d  = rx_data_q;
    tx_ready_d = tx_ready_q;
    miso_d     = miso_q;
    ovr_d      = ovr_q;
    rxv_d      = 1'b0;
    txd_d      = 1'b0;
    ferr_d     = 1'b0;

    if (tx_load && tx_ready_q) begin
      hold_d     = tx_data;
      tx_ready_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        miso_d = 1'b0;
        cnt_d  = '0;
        ovr_d  = 1'b0;
        if (cs_fall) begin
          state_d = S_SHIFT;
          rx_sh_d = '0;
          if (!tx_ready_q) begin
            tx_sh_d    = hold_q;
            tx_ready_d = 1'b1;
          end else begin
            tx_sh_d = '0;
            ferr_d  = 1'b1;
          end
        end else if (!cs_s) begin
          state_d = S_HOLD;
          ovr_d   = 1'b1;
        end
      end
      S_SHIFT: begin
        if (cnt_q == FULL) begin
          rx_data_d = rx_sh_q;
          rxv_d     = 1'b1;
          txd_d     = 1'b1;
          miso_d    = 1'b0;
          state_d   = S_HOLD;
        end else begin
          if (sclk_fall) begin
            miso_d  = tx_sh_q[DATA_WIDTH-1];
            tx_sh_d = tx_sh_q << 1;
          end
          if (sclk_rise) begin
            rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], mosi_s};
            cnt_d   = cnt_q + CW'(1);
          end
          // A cs_rise racing the last rise still completes the frame.
          if (cs_rise && !(sclk_rise && cnt_q == LAST)) begin
            ferr_d  = 1'b1;
            miso_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        miso_d = 1'b0;
        if (sclk_rise && !cs_s && !ovr_q) begin
          ferr_d = 1'b1;
          ovr_d  = 1'b1;
        end
        if (cs_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      hold_q     <= '0;
      rx_data_q  <= '0;
      tx_ready_q <= 1'b1;
      miso_q     <= 1'b0;
      ovr_q      <= 1'b0;
      rxv_q      <= 1'b0;
      txd_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      hold_q     <= hold_d;
      rx_data_q  <= rx_data_d;
      tx_ready_q <= tx_ready_d;
      miso_q     <= miso_d;
      ovr_q      <= ovr_d;
      rxv_q      <= rxv_d;
      txd_q      <= txd_d;
      ferr_q     <= ferr_d;
    end
  end

  assign miso        = miso_q;
  assign tx_ready    = tx_ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rxv_q;
  assign tx_done     = txd_q;
  assign frame_error = ferr_q;

endmodule

// File: tb/tb_spi_slave_endpoint.sv
// Bench for spi_slave_endpoint: drives a mode-3 master and checks against
// an expected-word queue plus hand-computed literals.
module tb_spi_slave_endpoint;

  logic        clk = 1'b0;
  logic        reset;
  logic        sclk;
  logic        cs_bar;
  logic        mosi;
  logic        miso;
  logic [15:0] tx_data;
  logic        tx_load;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        tx_done;
  logic        frame_error;

  spi_slave_endpoint #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .reset(reset),
    .sclk(sclk),
    .cs_bar(cs_bar),
    .mosi(mosi),
    .miso(miso),
    .tx_data(tx_data),
    .tx_load(tx_load),
    .tx_ready(tx_ready),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .tx_done(tx_done),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;
  int rxv_cnt = 0;
  int txd_cnt = 0;
  int fe_cnt  = 0;
  int cs_hi_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] model_rx = '0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the expected-word model.
  always @(negedge clk) begin
    if (reset) begin
      model_rx = '0;
      cs_hi_cnt = 0;
    end else begin
      chk("tx_done_eq_rx_valid", tx_done, rx_valid);
      if (rx_valid) begin
        chk("rx_valid_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) model_rx = exp_q.pop_front();
        rxv_cnt++;
      end
      chk("rx_data_model", rx_data, model_rx);
      if (tx_done) txd_cnt++;
      if (frame_error) fe_cnt++;
      cs_hi_cnt = cs_bar ? cs_hi_cnt + 1 : 0;
      if (cs_hi_cnt > 4) chk("miso_idle", miso, 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] w);
    tx_data = w;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
    tick(1);
  endtask

  task automatic spi_frame(input logic [15:0] mo, input int nrise,
                           input logic ld, input logic [15:0] ld_word,
                           output logic [15:0] mi, output logic rdy_mid);
    mi = '0;
    cs_bar = 1'b0;
    tick(2);
    if (ld) begin
      tx_data = ld_word;
      tx_load = 1'b1;
    end
    tick(1);
    tx_load = 1'b0;
    tick(1);
    rdy_mid = tx_ready;
    for (int i = 0; i < nrise; i++) begin
      sclk = 1'b0;
      mosi = (i < 16) ? mo[15-i] : 1'b0;
      tick(4);
      if (i < 16) mi = {mi[14:0], miso};
      sclk = 1'b1;
      tick(4);
    end
    cs_bar = 1'b1;
    tick(8);
  endtask

  int r0, t0, f0;
  task automatic mark();
    r0 = rxv_cnt;
    t0 = txd_cnt;
    f0 = fe_cnt;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] mi;
    logic        rdy;
    reset = 1'b1;
    sclk = 1'b1;
    cs_bar = 1'b1;
    mosi = 1'b0;
    tx_data = '0;
    tx_load = 1'b0;
    tick(3);
    chk("rst_miso", miso, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_frame_error", frame_error, 0);
    chk("rst_tx_ready", tx_ready, 1);
    reset = 1'b0;
    tick(10);
    chk("post_rst_pulses", fe_cnt + rxv_cnt, 0);

    // Normal frame with preloaded response
    mark();
    load(16'hA5C3);
    chk("t1_ready_low", tx_ready, 0);
    exp_q.push_back(16'h1234);
    spi_frame(16'h1234, 16, 1'b0, '0, mi, rdy);
    chk("t1_ready_at_fall", rdy, 1);
    chk("t1_miso", mi, 16'hA5C3);
    chk("t1_rx_data", rx_data, 16'h1234);
    chk("t1_rxv", rxv_cnt - r0, 1);
    chk("t1_txd", txd_cnt - t0, 1);
    chk("t1_fe", fe_cnt - f0, 0);
    chk("t1_ready_end", tx_ready, 1);

    // Underrun
    mark();
    exp_q.push_back(16'hFFFF);
    spi_frame(16'hFFFF, 16, 1'b0, '0, mi, rdy);
    chk("t2_miso", mi, 16'h0000);
    chk("t2_fe", fe_cnt - f0, 1);
    chk("t2_rx_data", rx_data, 16'hFFFF);
    chk("t2_rxv", rxv_cnt - r0, 1);

    // Short frame then recovery
    mark();
    load(16'h1111);
    spi_frame(16'hBEEF, 9, 1'b0, '0, mi, rdy);
    chk("t3_fe", fe_cnt - f0, 1);
    chk("t3_rxv", rxv_cnt - r0, 0);
    chk("t3_txd", txd_cnt - t0, 0);
    chk("t3_rx_kept", rx_data, 16'hFFFF);
    chk("t3_ready", tx_ready, 1);
    mark();
    load(16'h2222);
    exp_q.push_back(16'h0F0F);
    spi_frame(16'h0F0F, 16, 1'b0, '0, mi, rdy);
    chk("t3b_miso", mi, 16'h2222);
    chk("t3b_rx_data", rx_data, 16'h0F0F);
    chk("t3b_fe", fe_cnt - f0, 0);
    chk("t3b_rxv", rxv_cnt - r0, 1);

    // Overrun: 18 rises
    mark();
    load(16'h3333);
    exp_q.push_back(16'h8001);
    spi_frame(16'h8001, 18, 1'b0, '0, mi, rdy);
    chk("t4_miso", mi, 16'h3333);
    chk("t4_rx_data", rx_data, 16'h8001);
    chk("t4_fe", fe_cnt - f0, 1);
    chk("t4_rxv", rxv_cnt - r0, 1);

    // Reset at bit 7 with cs held low
    mark();
    load(16'h4444);
    cs_bar = 1'b0;
    tick(4);
    for (int i = 0; i < 7; i++) begin
      sclk = 1'b0;
      mosi = i[0];
      tick(4);
      sclk = 1'b1;
      tick(4);
    end
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(8);
    chk("t5_rx_cleared", rx_data, 16'h0000);
    chk("t5_ready", tx_ready, 1);
    cs_bar = 1'b1;
    tick(8);
    load(16'h6666);
    exp_q.push_back(16'h5555);
    spi_frame(16'h5555, 16, 1'b0, '0, mi, rdy);
    chk("t5_miso", mi, 16'h6666);
    chk("t5_rx_data", rx_data, 16'h5555);
    chk("t5_fe", fe_cnt - f0, 0);
    chk("t5_rxv", rxv_cnt - r0, 1);

    // tx_load coincident with cs_fall, holding empty
    mark();
    exp_q.push_back(16'hC3C3);
    spi_frame(16'hC3C3, 16, 1'b1, 16'h0F0F, mi, rdy);
    chk("t6_ready_mid", rdy, 0);
    chk("t6_miso", mi, 16'h0000);
    chk("t6_fe", fe_cnt - f0, 1);
    chk("t6_ready_end", tx_ready, 0);
    mark();
    exp_q.push_back(16'h3C3C);
    spi_frame(16'h3C3C, 16, 1'b0, '0, mi, rdy);
    chk("t6b_miso", mi, 16'h0F0F);
    chk("t6b_fe", fe_cnt - f0, 0);
    chk("t6b_rx_data", rx_data, 16'h3C3C);
    chk("t6b_ready", tx_ready, 1);

    chk("queue_drained", exp_q.size(), 0);
    tick(4);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
